// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence detector: pattern/length/target loaded over a
// valid/ready handshake, then a control FSM scans a qualified bit stream.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic [CNT_W-1:0]           cfg_target,
    output logic                       cfg_err,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       a,
    input  logic                       a_valid,
    output logic                       detected,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           match_count
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_loaded;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_target;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_detected;
    logic               r_cfg_err;
    logic [CNT_W-1:0]   r_count;

    logic               w_cfg_acc;
    logic               w_len_ok;
    logic               w_loaded_eff;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign cfg_ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign detected    = r_detected;
    assign cfg_err     = r_cfg_err;
    assign match_count = r_count;

    assign w_cfg_acc    = cfg_valid && cfg_ready;
    assign w_len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // A config accepted in the same cycle as start arms the detector with it.
    assign w_loaded_eff = r_loaded || (w_cfg_acc && w_len_ok);

    assign w_hist_next = {r_hist[MAX_LEN-2:0], a};
    assign w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    assign w_cnt_inc   = (&r_count) ? r_count : r_count + CNT_W'(1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = (w_fill_next >= r_len) && (((w_hist_next ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_loaded   <= 1'b0;
            r_pat      <= '0;
            r_len      <= '0;
            r_target   <= '0;
            r_hist     <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_detected <= 1'b0;
            r_cfg_err  <= 1'b0;

            if (w_cfg_acc) begin
                if (w_len_ok) begin
                    r_pat    <= cfg_pattern;
                    r_len    <= cfg_len;
                    r_target <= cfg_target;
                    r_loaded <= 1'b1;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end

            // stop wins over start and over a match landing in the same cycle
            if (stop) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && w_loaded_eff) begin
                            r_state <= ST_RUN;
                            r_hist  <= '0;
                            r_fill  <= '0;
                            r_count <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (a_valid) begin
                            r_hist <= w_hist_next;
                            r_fill <= w_fill_next;
                            if (w_match) begin
                                r_detected <= 1'b1;
                                r_count    <= w_cnt_inc;
                                if ((r_target != '0) && (w_cnt_inc == r_target)) begin
                                    r_state <= ST_DONE;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            r_state <= ST_RUN;
                            r_hist  <= '0;
                            r_fill  <= '0;
                            r_count <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial sequence detector with its own control FSM. Software/upstream loads a pattern (1..MAX_LEN bits), its length and an optional match target over a valid/ready config handshake. The block then arms, scans a qualified serial bit stream, pulses on every (overlapping) match, counts matches and stops itself when the target is reached. It replaces the fixed-pattern hard-coded detector FSMs with one reusable, configurable detector.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter and target

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  asynchronous, active-low reset
cfg_valid  input  1  config word valid
cfg_ready  output  1  block accepts config (IDLE or DONE)
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  input  $clog2(MAX_LEN)+1  pattern length, legal 1..MAX_LEN
cfg_target  input  CNT_W  matches before auto-stop; 0 = unlimited
cfg_err  output  1  one-cycle pulse: config rejected
start  input  1  arm detector (single-cycle pulse)
stop  input  1  abort back to IDLE
a  input  1  serial data bit
a_valid  input  1  qualifies a; bubbles allowed
detected  output  1  one-cycle pulse per match
busy  output  1  high in RUN
done  output  1  high in DONE (target reached)
match_count  output  CNT_W  matches since last start

Behaviour:
- Reset (rst=0, async): state IDLE, config-loaded flag 0, history/fill 0; detected=0, busy=0, done=0, cfg_err=0, match_count=0; cfg_ready=1 (decoded from IDLE).
- States: IDLE, RUN, DONE. cfg_ready = (IDLE|DONE); busy = RUN; done = DONE.
- Config (IDLE/DONE): on cfg_valid&cfg_ready, if 1<=cfg_len<=MAX_LEN latch pattern/len/target, set loaded flag; else pulse cfg_err next cycle, keep previous config. cfg_valid in RUN is not accepted (cfg_ready=0).
- IDLE: start with loaded=1 -> RUN, clear history, fill count, match_count. start with loaded=0 ignored. Config and start in same cycle: the new config is latched and RUN uses it.
- RUN: on a_valid, history shifts left, new bit in [0]; fill saturates at MAX_LEN. Match when fill_next>=len and the low len bits of history_next equal the low len bits of pattern. Overlap allowed; history is not cleared on match. a_valid=0 cycles hold history (no reset of partial match).
- detected is registered: high exactly in the cycle after the a_valid cycle carrying the final pattern bit. match_count increments in that same edge, saturates at 2^CNT_W-1.
- If target!=0 and the increment makes match_count==target -> DONE on the same edge (detected still pulses). Further a ignored.
- DONE: match_count frozen, done held. start -> RUN (clears count/history). stop -> IDLE. Config accepted.
- stop (any state) -> IDLE next edge; has priority over start and over a match in the same cycle: that match gives no detected, no count. match_count holds its value in IDLE until next start.
- start while in RUN: ignored.
- Reset mid-RUN: immediate return to reset values; config-loaded flag cleared, config must be reloaded.

Test Plan:
1. cfg 110011 (len 6, target 0), start, stream 1,1,0,0,1,1,0,0,1,1 -> detected one cycle after bit 6 and after bit 10 (overlap), match_count=2, busy stays 1.
2. cfg 101 len 3 target 2, stream 1,0,1,0,1,1,0,1 -> detected after bits 3 and 5, done=1 and busy=0 from cycle after bit 5, match_count stays 2; start -> count 0, busy 1.
3. Pattern 1010 with a_valid=0 bubbles of 1–3 cycles between every bit -> single detected one cycle after the 4th valid bit; no false match from held a during bubbles.
4. cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err pulse, no loaded flag; subsequent start ignored (busy stays 0); cfg in RUN -> cfg_ready=0, config unchanged.
5. stop asserted in cycle of final bit of 11 -> no detected, count unchanged, IDLE next edge; rst low mid-RUN -> all outputs to reset values asynchronously, start after release ignored until reconfigured.
6. len=MAX_LEN all-ones pattern, CNT_W=2, target 0, 12 consecutive 1s -> first detected after bit 8, then each cycle; match_count saturates at 3.
